cnn_mac_seq: RTL and testbench
==============================

CNN_MAC_SEQ -- requirements
Module: cnn_mac_seq

Interface
REQ-001 SHALL have parameter LEN_W, default 8, meaning the width of the dot-product length and of the operand address.
REQ-002 SHALL have parameter ACC_W, default 32, meaning the accumulator and result width; the legal range is ACC_W >= 23+LEN_W.
REQ-003 SHALL have port ap_clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port ap_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port ap_start, input, 1 bit: job request, sampled only in IDLE.
REQ-006 SHALL have port len, input, LEN_W bits: number of products; latched when a start is accepted.
REQ-007 SHALL have ports w_address0 and x_address0, outputs, LEN_W bits each: operand read addresses.
REQ-008 SHALL have ports w_ce0 and x_ce0, outputs, 1 bit each: read enables.
REQ-009 SHALL have port w_q0, input, 9 bits: signed weight; valid one cycle after its ce.
REQ-010 SHALL have port x_q0, input, 14 bits: signed activation (W14_6); valid one cycle after its ce.
REQ-011 SHALL have ports ap_idle, ap_ready and ap_done, outputs, 1 bit each: block-level handshake.
REQ-012 SHALL have port result, output, ACC_W bits: signed dot product.

Function
REQ-013 SHALL implement states IDLE, FETCH, DRAIN and DONE.
REQ-014 SHALL, in IDLE with ap_start=1 and len>0, latch len, clear the accumulator and go to FETCH.
REQ-015 SHALL, in IDLE with ap_start=1 and len=0, clear the accumulator and go to DONE.
REQ-016 SHALL, in FETCH, assert both ce signals every cycle, with both addresses equal to index i; i starts at 0.
REQ-017 SHALL increment i by one per FETCH cycle and go to DRAIN after issuing i=len-1.
REQ-018 SHALL form each product as signed 9 x signed 14 into 23 bits, registered one cycle after data arrives.
REQ-019 SHALL sign-extend each product to ACC_W and add it to the accumulator in the following cycle.
REQ-020 SHALL let the accumulator wrap modulo 2^ACC_W; overflow is impossible within the legal ACC_W range.
REQ-021 SHALL remain in DRAIN for exactly 2 cycles, then go to DONE.
REQ-022 SHALL, in DONE, assert ap_done and ap_ready for exactly one cycle, with result equal to the final sum, then return to IDLE.
REQ-023 SHALL hold result stable until the next start is accepted.
REQ-024 SHALL assert ap_done, with S the cycle in which ap_start is sampled in IDLE:
- len>0: in cycle S+len+3;
- len=0: in cycle S+1.
REQ-025 SHALL assert ap_idle iff the state is IDLE and ap_start=0.
REQ-026 SHALL ignore ap_start and len outside IDLE; back-to-back jobs are accepted in the IDLE cycle after DONE.

Reset
REQ-027 SHALL, while ap_rst=1, force the following on the next edge, from any state including mid-job: state IDLE, i=0, accumulator=0, result=0, ce=0, addresses=0, ap_done=0, ap_ready=0 and pipeline valids=0.
REQ-028 SHALL drive ap_idle=1 in the first cycle after reset release when ap_start=0.

Configuration
REQ-029 SHALL, with CNN_MAC_SEQ_RELU_EN defined, clamp result to 0 when the final sum is negative; the clamp is applied at the DONE register, so latency is unchanged.
REQ-030 SHALL, without CNN_MAC_SEQ_RELU_EN, present the signed sum unmodified.

Structure
REQ-031 SHALL place the state enum, the operand widths (9 and 14), the product width (23) and the ACC_W/LEN_W defaults in package cnn_mac_pkg.
REQ-032 SHALL instantiate one sub-module, cnn_mac_seq_mul: a registered signed 9x14->23 multiplier with one stage.

Verification
REQ-033 SHALL cover: len=3, w={2,-3,4}, x={100,50,-25} -> result=-50, ap_done in cycle S+6.
REQ-034 SHALL cover: len=0 -> no ce asserted, ap_done in cycle S+1, result=0.
REQ-035 SHALL cover: len=255, all w=-256, all x=-8192 -> result=534773760 with no wrap; with RELU_EN and x=+8191 -> result=0.
REQ-036 SHALL cover: two jobs back-to-back, ap_start held high -> second start accepted in the IDLE cycle after the first ap_done, and the accumulator is cleared.
REQ-037 SHALL cover: ap_rst pulsed in mid-FETCH of len=10 -> next cycle IDLE, ce=0, result=0, ap_done never asserted.
REQ-038 SHALL cover: ap_start toggled and len changed during FETCH -> no effect on the current result or timing.

Source files
------------

// File: rtl/cnn_mac_pkg.sv
// Shared types and widths for the sequential CNN multiply-accumulate block.
package cnn_mac_pkg;

  localparam int unsigned W_W       = 9;
  localparam int unsigned X_W       = 14;
  localparam int unsigned PROD_W    = 23;
  localparam int unsigned LEN_W_DEF = 8;
  localparam int unsigned ACC_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/cnn_mac_seq_mul.sv
// One-stage registered signed 9x14 -> 23 multiplier with a travelling valid bit.
module cnn_mac_seq_mul
  import cnn_mac_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  input  logic signed [W_W-1:0]    a,
  input  logic signed [X_W-1:0]    b,
  output logic signed [PROD_W-1:0] p,
  output logic                     p_vld
);

  logic signed [PROD_W-1:0] p_q, p_d;
  logic                     vld_q, vld_d;

  // Both operands are sign-extended to the product width, so the product is exact.
  always_comb begin
    p_d   = PROD_W'(a) * PROD_W'(b);
    vld_d = in_vld;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      vld_q <= vld_d;
    end
  end

  assign p     = p_q;
  assign p_vld = vld_q;

endmodule

// File: rtl/cnn_mac_seq.sv
// Sequential dot-product engine: fetches len weight/activation pairs and accumulates their products.
// Optional CNN_MAC_SEQ_RELU_EN clamps a negative final sum to zero.
module cnn_mac_seq
  import cnn_mac_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    ap_start,
  input  logic [LEN_W-1:0]        len,
  output logic [LEN_W-1:0]        w_address0,
  output logic                    w_ce0,
  input  logic signed [W_W-1:0]   w_q0,
  output logic [LEN_W-1:0]        x_address0,
  output logic                    x_ce0,
  input  logic signed [X_W-1:0]   x_q0,
  output logic                    ap_idle,
  output logic                    ap_ready,
  output logic                    ap_done,
  output logic signed [ACC_W-1:0] result
);

  state_e                   state_q, state_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [LEN_W-1:0]         i_q, i_d;
  logic                     drain_q, drain_d;
  logic                     ce_q, ce_d;
  logic                     dvld_q, dvld_d;
  logic                     done_q, done_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  result_q, result_d;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [PROD_W-1:0] prod;
  logic                     prod_vld;
  logic                     last_c;

  cnn_mac_seq_mul u_mul (
    .clk    (ap_clk),
    .rst    (ap_rst),
    .in_vld (dvld_q),
    .a      (w_q0),
    .b      (x_q0),
    .p      (prod),
    .p_vld  (prod_vld)
  );

  assign last_c = (i_q == (len_q - LEN_W'(1)));

  always_ff @(posedge ap_clk) begin
    if (ap_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ap_start) state_d = (len != '0) ? ST_FETCH : ST_DONE;
      ST_FETCH: if (last_c)   state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q)  state_d = ST_DONE;
      ST_DONE:                state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // The accumulator keeps absorbing products in every state, so the last one lands in the second DRAIN cycle.
  always_comb begin
    len_d    = len_q;
    i_d      = i_q;
    drain_d  = drain_q;
    prod_ext = prod_vld ? ACC_W'(prod) : ACC_W'(0);
    acc_d    = acc_q + prod_ext;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (ap_start) begin
          len_d = len;
          i_d   = '0;
          acc_d = '0;
        end
      end
      ST_FETCH: begin
        i_d     = last_c ? '0 : i_q + LEN_W'(1);
        drain_d = 1'b0;
      end
      ST_DRAIN: drain_d = ~drain_q;
      default:  ;
    endcase
    ce_d   = (state_d == ST_FETCH);
    dvld_d = ce_q;
    done_d = (state_d == ST_DONE);
    if (state_d == ST_DONE) begin
`ifdef CNN_MAC_SEQ_RELU_EN
      result_d = acc_d[ACC_W-1] ? '0 : acc_d;
`else
      result_d = acc_d;
`endif
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      len_q    <= '0;
      i_q      <= '0;
      drain_q  <= 1'b0;
      ce_q     <= 1'b0;
      dvld_q   <= 1'b0;
      done_q   <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      len_q    <= len_d;
      i_q      <= i_d;
      drain_q  <= drain_d;
      ce_q     <= ce_d;
      dvld_q   <= dvld_d;
      done_q   <= done_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign w_address0 = i_q;
  assign x_address0 = i_q;
  assign w_ce0      = ce_q;
  assign x_ce0      = ce_q;
  assign ap_done    = done_q;
  assign ap_ready   = done_q;
  assign result     = result_q;
  assign ap_idle    = (state_q == ST_IDLE) && !ap_start;

endmodule

// File: tb/tb_cnn_mac_seq.sv
// Scoreboard bench for cnn_mac_seq: expected sum and ap_done cycle are queued at start, checked on ap_done.
module tb_cnn_mac_seq;

  logic               ap_clk = 1'b0;
  logic               ap_rst = 1'b1;
  logic               ap_start = 1'b0;
  logic [7:0]         len = '0;
  logic [7:0]         w_address0, x_address0;
  logic               w_ce0, x_ce0;
  logic signed [8:0]  w_q0 = '0;
  logic signed [13:0] x_q0 = '0;
  logic               ap_idle, ap_ready, ap_done;
  logic signed [31:0] result;

  cnn_mac_seq #(.LEN_W(8), .ACC_W(32)) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .ap_start   (ap_start),
    .len        (len),
    .w_address0 (w_address0),
    .w_ce0      (w_ce0),
    .w_q0       (w_q0),
    .x_address0 (x_address0),
    .x_ce0      (x_ce0),
    .x_q0       (x_q0),
    .ap_idle    (ap_idle),
    .ap_ready   (ap_ready),
    .ap_done    (ap_done),
    .result     (result)
  );

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  // Operand memories with one cycle of read latency.
  logic signed [8:0]  w_mem [256];
  logic signed [13:0] x_mem [256];
  always @(posedge ap_clk) begin
    if (w_ce0) w_q0 <= w_mem[w_address0];
    if (x_ce0) x_q0 <= x_mem[x_address0];
  end

  typedef struct {
    logic signed [31:0] res;
    int                 cyc;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic check_eq(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic signed [31:0] model(input int n);
    longint s = 0;
    logic signed [31:0] r;
    for (int i = 0; i < n; i++) s += longint'(w_mem[i]) * longint'(x_mem[i]);
    r = s[31:0];
`ifdef CNN_MAC_SEQ_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  always @(negedge ap_clk) begin
    if (ap_done) begin
      exp_t e;
      done_cnt++;
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", 64'(ap_done), 0);
      end else begin
        e = sb_q.pop_front();
        check_eq("result", result, e.res);
        check_eq("done_cycle", cyc, e.cyc);
        check_eq("ready_with_done", 64'(ap_ready), 1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge ap_clk);
  endtask

  task automatic start_job(input int n, input bit hold, output int s);
    ap_start = 1'b1;
    len      = 8'(n);
    s        = cyc;
    sb_q.push_back('{res: model(n), cyc: (n == 0) ? s + 1 : s + n + 3});
    if (!hold) begin
      tick(1);
      ap_start = 1'b0;
    end
  endtask

  task automatic wait_jobs(input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      tick(1);
      k++;
    end
    if (done_cnt < target) begin
      check_eq("timeout", done_cnt, target);
      sb_q.delete();
    end
    tick(1);
  endtask

  task automatic fill_const(input int n, input int wv, input int xv);
    for (int i = 0; i < n; i++) begin
      w_mem[i] = 9'(wv);
      x_mem[i] = 14'(xv);
    end
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) begin
      w_mem[i] = 9'($urandom);
      x_mem[i] = 14'($urandom);
    end
  endtask

  initial begin
    int s;
    int d0;
    logic signed [31:0] hold_val;
    fill_const(256, 0, 0);

    tick(3);
    ap_rst = 1'b0;
    tick(1);
    check_eq("rst_idle", 64'(ap_idle), 1);
    check_eq("rst_done", 64'(ap_done), 0);
    check_eq("rst_ready", 64'(ap_ready), 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_ce", 64'({w_ce0, x_ce0}), 0);
    check_eq("rst_addr", 64'(w_address0), 0);

    // Short signed job.
    w_mem[0] = 9'sd2;    w_mem[1] = -9'sd3;   w_mem[2] = 9'sd4;
    x_mem[0] = 14'sd100; x_mem[1] = 14'sd50;  x_mem[2] = -14'sd25;
    hold_val = model(3);
    start_job(3, 1'b0, s);
    wait_jobs(1, 20);
    tick(3);
    check_eq("result_hold", result, hold_val);
    check_eq("idle_after_job", 64'(ap_idle), 1);

    // Zero length: straight to DONE with no fetches.
    start_job(0, 1'b0, s);
    check_eq("len0_no_wce", 64'(w_ce0), 0);
    check_eq("len0_no_xce", 64'(x_ce0), 0);
    wait_jobs(2, 10);

    // Largest magnitude, both signs of activation.
    fill_const(255, -256, -8192);
    start_job(255, 1'b0, s);
    wait_jobs(3, 300);
    fill_const(255, -256, 8191);
    start_job(255, 1'b0, s);
    wait_jobs(4, 300);

    // Back-to-back with ap_start held: second job starts the cycle after the first DONE.
    fill_rand(6);
    start_job(6, 1'b1, s);
    sb_q.push_back('{res: model(6), cyc: s + 10 + 6 + 3});
    tick(11);
    ap_start = 1'b0;
    wait_jobs(6, 40);

    // Start and len toggled during FETCH must not disturb the job.
    fill_rand(5);
    start_job(5, 1'b0, s);
    for (int k = 0; k < 3; k++) begin
      ap_start = 1'($urandom);
      len      = 8'($urandom);
      tick(1);
    end
    ap_start = 1'b0;
    len      = 8'd5;
    wait_jobs(7, 30);

    // Reset in the middle of a FETCH phase aborts the job silently.
    fill_rand(10);
    ap_start = 1'b1;
    len      = 8'd10;
    tick(1);
    ap_start = 1'b0;
    tick(3);
    ap_rst = 1'b1;
    tick(1);
    check_eq("midrst_ce", 64'({w_ce0, x_ce0}), 0);
    check_eq("midrst_result", result, 0);
    check_eq("midrst_addr", 64'(x_address0), 0);
    ap_rst = 1'b0;
    check_eq("midrst_idle", 64'(ap_idle), 1);
    d0 = done_cnt;
    tick(20);
    check_eq("midrst_no_done", done_cnt, d0);

    // Random job after the abort.
    fill_rand(17);
    start_job(17, 1'b0, s);
    wait_jobs(8, 40);

    check_eq("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
